// File: rtl/pc_unit_ras.sv
// -----------------------------------------------------------------------------
// pc_unit_ras
//
// Program counter for the RISC-V fetch stage. Besides load/increment it
// supports stall, prioritised trap/redirect handling, redirect-target
// alignment checking, and a small circular return-address stack (RAS) used
// to predict the target of a return.
//
// Update priority, highest first:
//   trap_en > redirect_en (+call_en push) > ret_en (unstalled) > stall > +INC
//
// Ports:
//   clk            in   rising-edge clock
//   clr            in   synchronous reset, active high
//   stall          in   hold PC; blocks ret and increment only
//   trap_en        in   force PC to TRAP_VEC and flush the RAS
//   redirect_en    in   load redirect_addr (low ALIGN_BITS cleared)
//   redirect_addr  in   branch/jump target
//   call_en        in   push pc_plus onto the RAS; only with redirect_en
//   ret_en         in   pop the RAS into the PC
//   pc             out  current PC, registered
//   pc_plus        out  pc + INC, wraps at 2^XLEN
//   ras_count      out  number of valid RAS entries
//   ras_empty      out  ras_count == 0
//   ras_full       out  ras_count == RAS_DEPTH
//   misalign       out  one-cycle pulse: redirect target had low bits set
//   ret_underflow  out  one-cycle pulse: return with an empty RAS
// -----------------------------------------------------------------------------
module pc_unit_ras #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_VEC  = 'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VEC   = 'h0000_0100,
    parameter int                INC        = 4,
    parameter int                ALIGN_BITS = 2,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           stall,
    input  logic                           trap_en,
    input  logic                           redirect_en,
    input  logic [XLEN-1:0]                redirect_addr,
    input  logic                           call_en,
    input  logic                           ret_en,
    output logic [XLEN-1:0]                pc,
    output logic [XLEN-1:0]                pc_plus,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           misalign,
    output logic                           ret_underflow
);

    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              COUNT_W    = PTR_W + 1;
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_ras [RAS_DEPTH];
    // r_wptr is the slot the next push writes; the top entry sits just below it.
    logic [PTR_W-1:0]   r_wptr;
    logic [COUNT_W-1:0] r_count;
    logic               r_misalign;
    logic               r_ret_underflow;

    logic [XLEN-1:0]    w_pc_plus;
    logic [PTR_W-1:0]   w_top_idx;
    logic [XLEN-1:0]    w_low_bits;

    // Additions wrap naturally at 2^XLEN because the result is XLEN bits wide.
    assign w_pc_plus  = r_pc + INC_V;
    // RAS_DEPTH is a power of two, so pointer arithmetic wraps around the ring.
    assign w_top_idx  = r_wptr - PTR_W'(1);
    assign w_low_bits = redirect_addr & ~ALIGN_MASK;

    // NOTE: the RAS storage has no reset; ras_count alone defines which entries
    // are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: all state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            r_pc            <= RESET_VEC;
            r_wptr          <= '0;
            r_count         <= '0;
            r_misalign      <= 1'b0;
            r_ret_underflow <= 1'b0;
        end else begin
            // Pulses default low; only the event cycle raises them.
            r_misalign      <= 1'b0;
            r_ret_underflow <= 1'b0;

            if (trap_en) begin
                r_pc    <= TRAP_VEC;
                r_count <= '0;
            end else if (redirect_en) begin
                r_pc       <= redirect_addr & ALIGN_MASK;
                r_misalign <= (w_low_bits != '0);
                if (call_en) begin
                    // When full, this overwrites the oldest entry and the
                    // count saturates.
                    r_ras[r_wptr] <= w_pc_plus;
                    r_wptr        <= r_wptr + PTR_W'(1);
                    if (r_count != FULL_CNT) begin
                        r_count <= r_count + COUNT_W'(1);
                    end
                end
            end else if (ret_en && !stall) begin
                if (r_count != '0) begin
                    r_pc    <= r_ras[w_top_idx];
                    r_wptr  <= w_top_idx;
                    r_count <= r_count - COUNT_W'(1);
                end else begin
                    r_pc            <= w_pc_plus;
                    r_ret_underflow <= 1'b1;
                end
            end else if (!stall) begin
                r_pc <= w_pc_plus;
            end
        end
    end

    assign pc            = r_pc;
    assign pc_plus       = w_pc_plus;
    assign ras_count     = r_count;
    assign ras_empty     = (r_count == '0);
    assign ras_full      = (r_count == FULL_CNT);
    assign misalign      = r_misalign;
    assign ret_underflow = r_ret_underflow;

endmodule

// File: tb/tb_pc_unit_ras.sv
// -----------------------------------------------------------------------------
// tb_pc_unit_ras
//
// Scoreboard bench for pc_unit_ras (default parameters). A driver issues one
// stimulus per cycle on the falling edge, advances a behavioural model (PC as
// a number, RAS as a bounded queue) and pushes the expected post-edge state.
// A monitor samples the DUT 1 time unit after each rising edge and compares
// against the oldest expected entry.
// -----------------------------------------------------------------------------
module tb_pc_unit_ras;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_V = 32'h0000_0000;
    localparam logic [31:0] TRP_V = 32'h0000_0100;

    logic              clk;
    logic              clr;
    logic              stall;
    logic              trap_en;
    logic              redirect_en;
    logic [XLEN-1:0]   redirect_addr;
    logic              call_en;
    logic              ret_en;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus;
    logic [2:0]        ras_count;
    logic              ras_empty;
    logic              ras_full;
    logic              misalign;
    logic              ret_underflow;

    pc_unit_ras dut (
        .clk          (clk),
        .clr          (clr),
        .stall        (stall),
        .trap_en      (trap_en),
        .redirect_en  (redirect_en),
        .redirect_addr(redirect_addr),
        .call_en      (call_en),
        .ret_en       (ret_en),
        .pc           (pc),
        .pc_plus      (pc_plus),
        .ras_count    (ras_count),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .misalign     (misalign),
        .ret_underflow(ret_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        int          count;
        logic        mis;
        logic        und;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: next state from the rules, PC as plain arithmetic and
    // the RAS as a queue whose back is the top entry.
    task automatic model_step(output exp_t e);
        e.mis = 1'b0;
        e.und = 1'b0;
        if (clr) begin
            m_pc = RST_V;
            m_ras.delete();
        end else if (trap_en) begin
            m_pc = TRP_V;
            m_ras.delete();
        end else if (redirect_en) begin
            if (call_en) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            e.mis = (redirect_addr % 4) != 0;
            m_pc  = redirect_addr - (redirect_addr % 4);
        end else if (ret_en && !stall) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = m_pc + 32'd4;
                e.und = 1'b1;
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
        e.pc    = m_pc;
        e.count = m_ras.size();
    endtask

    task automatic drive(input logic c, input logic s, input logic t, input logic r,
                         input logic [31:0] a, input logic cl, input logic rt);
        exp_t e;
        @(negedge clk);
        clr           = c;
        stall         = s;
        trap_en       = t;
        redirect_en   = r;
        redirect_addr = a;
        call_en       = cl;
        ret_en        = rt;
        model_step(e);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    // Monitor: every sampled cycle with an outstanding expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc",            pc,                      e.pc);
                check("pc_plus",       pc_plus,                 e.pc + 32'd4);
                check("ras_count",     32'(ras_count),          32'(e.count));
                check("ras_empty",     32'(ras_empty),          32'(e.count == 0));
                check("ras_full",      32'(ras_full),           32'(e.count == DEPTH));
                check("misalign",      32'(misalign),           32'(e.mis));
                check("ret_underflow", 32'(ret_underflow),      32'(e.und));
            end
        end
    end

    initial begin
        int r;
        logic [31:0] a;
        clr = 1'b1; stall = 1'b0; trap_en = 1'b0; redirect_en = 1'b0;
        redirect_addr = '0; call_en = 1'b0; ret_en = 1'b0;
        m_pc = RST_V;

        // Reset, then free-running increment up to 0x10.
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        idle(4);
        // Stall three cycles at 0x10, then release.
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 32'h0, 0, 0);
        idle(1);
        // Call from 0x20 to 0x200, return two cycles later to 0x24.
        drive(0, 0, 0, 1, 32'h20, 0, 0);
        drive(0, 0, 0, 1, 32'h200, 1, 0);
        idle(1);
        drive(0, 0, 0, 0, 32'h0, 0, 1);
        // Five calls into a four-deep RAS, then five returns (last underflows).
        for (int i = 1; i <= 5; i++) drive(0, 0, 0, 1, 32'(i) << 12, 1, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 32'h0, 0, 1);
        // Stalled return does not pop; ret with redirect does not pop.
        drive(0, 0, 0, 1, 32'h400, 1, 0);
        drive(0, 1, 0, 0, 32'h0, 0, 1);
        drive(0, 0, 0, 1, 32'h800, 1, 1);
        // Trap beats redirect/ret/stall with two entries on the RAS.
        drive(0, 1, 1, 1, 32'h203, 1, 1);
        // Misaligned redirect, then wrap-around at the top of the address space.
        drive(0, 0, 0, 1, 32'h203, 0, 0);
        idle(1);
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        idle(2);
        // Reset mid-operation with a stall and non-empty RAS.
        drive(0, 0, 0, 1, 32'h300, 1, 0);
        drive(1, 1, 0, 0, 32'h0, 0, 1);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 | {28'h0, a[3:0]};
            drive(r < 2,
                  $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 30,
                  a,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 35);
        end
        idle(1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
